btn_event_ctrl: RTL and testbench
=================================

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000: clk cycles per sample tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter HOLD_TICKS, default 500: ticks of stable debounced press before a HOLD event; legal range 1..4095.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state rises on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port button, input, 4 bits: raw asynchronous push-button levels, 1 = pressed.
REQ-006 SHALL have port level, output, 4 bits: debounced button levels.
REQ-007 SHALL have port ev_valid, output, 1 bit: the event FIFO head is valid.
REQ-008 SHALL have port ev_data, output, 4 bits: FIFO head as {type[1:0], id[1:0]}; type 01 = PRESS, 10 = RELEASE, 11 = HOLD.
REQ-009 SHALL have port ev_ready, input, 1 bit: consumer accepts the head.
REQ-010 SHALL have port ovf, output, 1 bit: sticky flag, set when any event is dropped.
REQ-011 SHALL have port ovf_clr, input, 1 bit: clears ovf synchronously.

Function
REQ-012 SHALL pass each button bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL use a prescaler counting 0..TICK_DIV-1 and wrapping to 0; tick is high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-014 SHALL, on tick, shift each synchronized bit into that button's 8-bit history, new sample at bit 0.
REQ-015 SHALL set level[i] to 1 when history[i] becomes 8'hFF and to 0 when it becomes 8'h00; any other history value holds level[i].
REQ-016 SHALL update level one cycle after the tick that completes the history, and never more than once per tick.
REQ-017 SHALL raise pending[i] with type PRESS on a 0->1 level change and with type RELEASE on a 1->0 level change, in the same cycle the level changes.
REQ-018 SHALL keep a per-button 12-bit hold counter: cleared while level[i]=0, incremented on each tick while level[i]=1, saturating at HOLD_TICKS.
REQ-019 SHALL raise pending[i] with type HOLD exactly once per press, in the cycle the hold counter reaches HOLD_TICKS.
REQ-020 SHALL, if pending[i] is already set when a new event for button i arises, drop the new event, keep the old one, and set ovf.
REQ-021 SHALL, each cycle, push the pending event with the lowest index into the FIFO and clear that pending bit, at most one push per cycle.
REQ-022 SHALL allow a push when the FIFO holds fewer than 4 entries, or when it holds 4 and a pop occurs in the same cycle; otherwise pending events wait.
REQ-023 SHALL implement the FIFO as 4 entries with a 3-bit count; ev_valid = (count != 0); ev_data = head entry.
REQ-024 SHALL pop when ev_valid and ev_ready are both high; ev_data and ev_valid SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and deliver entries in FIFO order.
REQ-026 SHALL, when ovf_clr and a drop coincide, leave ovf set (set wins).
REQ-027 SHALL ignore ev_ready while ev_valid=0.

Reset
REQ-028 SHALL, while rst_n=0, immediately force to 0: the prescaler, synchronizers, histories, level, hold counters, pending bits, FIFO pointers and count, ev_valid and ovf.
REQ-029 SHALL hold ev_data at 4'b0000 while the FIFO is empty.
REQ-030 SHALL discard any in-progress debounce, hold count and queued events on reset, and resume with the first tick TICK_DIV cycles after rst_n deasserts.

Verification (TICK_DIV=4, HOLD_TICKS=3)
REQ-031 SHALL cover: button[0] 0->1 and held, ev_ready=1 -> level[0]=1 after 8 ticks (+ sync latency); event PRESS, id 0 (ev_data=4'b0100); 3 ticks later HOLD, id 0 (4'b1100), once only.
REQ-032 SHALL cover: button[2] toggles every 3 ticks -> level stays 0 and no events.
REQ-033 SHALL cover: buttons 3 and 1 become stable on the same tick -> ev_data 4'b0101 then 4'b0111, on consecutive FIFO pops.
REQ-034 SHALL cover: ev_ready=0 while 5 distinct events occur -> count=4, the fifth stays pending, ovf=0; 6th event on the pending button -> ovf=1; ovf_clr -> ovf=0.
REQ-035 SHALL cover: full FIFO with ev_ready=1 and a pending event -> push and pop in the same cycle, count stays 4, order preserved.
REQ-036 SHALL cover: rst_n pulsed low mid-debounce with 2 events queued -> ev_valid=0 and level=0 immediately; no events until 8 fresh ticks have elapsed.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl
//   Debounces four push buttons and reports PRESS / RELEASE / HOLD events
//   through a 4-entry event FIFO.
//
//   Parameters
//     TICK_DIV   : clk cycles per sample tick (2..2^20)
//     HOLD_TICKS : ticks of stable debounced press before a HOLD event (1..4095)
//
//   Ports
//     clk       : single clock, all state on posedge
//     rst_n     : asynchronous active-low reset
//     button    : raw asynchronous button levels, 1 = pressed
//     level     : debounced button levels
//     ev_valid  : FIFO head is valid
//     ev_data   : FIFO head {type[1:0], id[1:0]}; 01 PRESS, 10 RELEASE, 11 HOLD
//     ev_ready  : consumer accepts the head
//     ovf       : sticky, set when an event is dropped
//     ovf_clr   : synchronous clear of ovf (a drop in the same cycle wins)
//
//   Handshake: a pop happens on a cycle where ev_valid && ev_ready. While
//   ev_valid=1 and ev_ready=0, ev_valid and ev_data hold. ev_ready is ignored
//   while ev_valid=0. ev_data reads 0 while the FIFO is empty.
// -----------------------------------------------------------------------------
module btn_event_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_TICKS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] button,
  output logic [3:0] level,
  output logic       ev_valid,
  output logic [3:0] ev_data,
  input  logic       ev_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
  localparam logic [11:0] HOLD_MAX  = 12'(HOLD_TICKS);

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_HOLD    = 2'b11;

  // synchronizer
  logic [3:0] sync1;
  logic [3:0] sync2;

  // prescaler
  logic [19:0] pre_cnt;
  logic        tick;
  logic        tick_d;

  // debounce and hold tracking
  logic [7:0]  hist     [4];
  logic [11:0] hold_cnt [4];
  logic [3:0]  level_nxt;

  // event sources and pending slots
  logic [3:0] new_ev;
  logic [1:0] new_type [4];
  logic [3:0] pend;
  logic [1:0] ptype    [4];

  // FIFO
  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       pop;
  logic       push;
  logic [1:0] push_idx;
  logic [3:0] push_data;

  assign tick = (pre_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 4'd0;
      sync2   <= 4'd0;
      pre_cnt <= 20'd0;
      tick_d  <= 1'b0;
    end else begin
      sync1   <= button;
      sync2   <= sync1;
      pre_cnt <= tick ? 20'd0 : pre_cnt + 20'd1;
      tick_d  <= tick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
    end else if (tick) begin
      for (int i = 0; i < 4; i++) hist[i] <= {hist[i][6:0], sync2[i]};
    end
  end

  // Level is evaluated in the cycle after a tick, when the freshly shifted
  // history is visible; tick_d is high for only that one cycle per tick.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < 4; i++) begin
      if (tick_d) begin
        if (hist[i] == 8'hFF)      level_nxt[i] = 1'b1;
        else if (hist[i] == 8'h00) level_nxt[i] = 1'b0;
      end
    end
  end

  // Level edges happen on tick_d cycles and HOLD on tick cycles, so a button
  // never produces two events in the same cycle.
  always_comb begin
    new_ev = 4'd0;
    for (int i = 0; i < 4; i++) begin
      new_type[i] = 2'b00;
      if (level_nxt[i] != level[i]) begin
        new_ev[i]   = 1'b1;
        new_type[i] = level_nxt[i] ? EV_PRESS : EV_RELEASE;
      end else if (tick && level[i] && (hold_cnt[i] == HOLD_MAX - 12'd1)) begin
        new_ev[i]   = 1'b1;
        new_type[i] = EV_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 4'd0;
      for (int i = 0; i < 4; i++) hold_cnt[i] <= 12'd0;
    end else begin
      level <= level_nxt;
      for (int i = 0; i < 4; i++) begin
        if (!level[i])
          hold_cnt[i] <= 12'd0;
        else if (tick && (hold_cnt[i] < HOLD_MAX))
          hold_cnt[i] <= hold_cnt[i] + 12'd1;
      end
    end
  end

  // Lowest-index pending slot wins the single push per cycle.
  always_comb begin
    push_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) push_idx = 2'(i);
    end
    push_data = {ptype[push_idx], push_idx};
  end

  assign ev_valid = (count != 3'd0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : 4'd0;
  assign pop      = ev_valid && ev_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = (|pend) && ((count != 3'd4) || pop);

  // A slot that is already occupied keeps its old event; the new one is
  // dropped even if the old one is being pushed this very cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 4'd0;
      for (int i = 0; i < 4; i++) ptype[i] <= 2'b00;
      ovf  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (new_ev[i] && !pend[i]) begin
          pend[i]  <= 1'b1;
          ptype[i] <= new_type[i];
        end else if (push && (push_idx == 2'(i))) begin
          pend[i] <= 1'b0;
        end
      end
      if (|(new_ev & pend)) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_event_ctrl
//   Directed vector table, hand-written multi-cycle sequences (glitch
//   rejection, reset mid-debounce) and a randomized run checked cycle by
//   cycle against a behavioural model: debounce as run-length of equal
//   samples, hold as tick count since press, FIFO as a queue.
// -----------------------------------------------------------------------------
module tb_btn_event_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] button = 4'd0;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] level;
  logic       ev_valid;
  logic [3:0] ev_data;
  logic       ovf;

  always #5 clk = ~clk;

  btn_event_ctrl #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .button   (button),
    .level    (level),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .ev_ready (ev_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_s1, m_s2, m_level, m_pend, m_run_val;
  int         m_run_len [4];
  int         m_hold    [4];
  logic [1:0] m_ptype   [4];
  int         m_cnt;
  logic       m_tick_d;
  logic       m_ovf;
  logic [3:0] exp_q [$];

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pend = 0; m_run_val = 0;
    for (int i = 0; i < 4; i++) begin
      m_run_len[i] = 8;  // reset history reads as eight zero samples
      m_hold[i] = 0;
      m_ptype[i] = 0;
    end
    m_cnt = 0; m_tick_d = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic       tick, pop, drop;
    logic [3:0] nlev, ev, old_pend;
    logic [1:0] et [4];
    int         p;
    tick = (m_cnt == TICK_DIV - 1);
    old_pend = m_pend;
    nlev = m_level;
    for (int i = 0; i < 4; i++)
      if (m_tick_d && m_run_len[i] >= 8) nlev[i] = m_run_val[i];
    ev = 0;
    for (int i = 0; i < 4; i++) begin
      et[i] = 2'b00;
      if (nlev[i] != m_level[i]) begin
        ev[i] = 1; et[i] = nlev[i] ? 2'b01 : 2'b10;
      end else if (tick && m_level[i] && m_hold[i] == HOLD_TICKS - 1) begin
        ev[i] = 1; et[i] = 2'b11;
      end
    end
    pop = (exp_q.size() != 0) && ev_ready;
    p = -1;
    for (int i = 3; i >= 0; i--) if (old_pend[i]) p = i;
    if (pop) void'(exp_q.pop_front());
    if (p >= 0 && (exp_q.size() < 4)) begin
      exp_q.push_back({m_ptype[p], 2'(p)});
      m_pend[p] = 0;
    end
    drop = 0;
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) begin
        if (old_pend[i]) drop = 1;
        else begin m_pend[i] = 1; m_ptype[i] = et[i]; end
      end
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m_level[i]) m_hold[i] = 0;
      else if (tick && m_hold[i] < HOLD_TICKS) m_hold[i]++;
    end
    m_level = nlev;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_run_val[i]) begin
          if (m_run_len[i] < 8) m_run_len[i]++;
        end else begin
          m_run_val[i] = m_s2[i];
          m_run_len[i] = 1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = button;
    m_cnt = tick ? 0 : m_cnt + 1;
    m_tick_d = tick;
  endtask

  // one clock: advance the model with the inputs present at the edge, then
  // settle #1 past the edge for sampling and driving
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] button;
    logic       rdy;
    logic       clr;
    int         ncyc;
    logic [3:0] exp_level;
    logic       exp_valid;
    logic [3:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [11];

  int pct_tbl [5];

  initial begin
    // press b0 -> PRESS0, HOLD0 queued
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 80, 4'b0001, 1'b1, 4'b0100, 1'b0};
    // b1 and b3 on same tick -> PRESS1, PRESS3 fill FIFO; HOLD1/HOLD3 pending
    vecs[1]  = '{4'b1011, 1'b0, 1'b0, 80, 4'b1011, 1'b1, 4'b0100, 1'b0};
    // release b3 while its HOLD is pending -> dropped, ovf
    vecs[2]  = '{4'b0011, 1'b0, 1'b0, 80, 4'b0011, 1'b1, 4'b0100, 1'b1};
    vecs[3]  = '{4'b0011, 1'b0, 1'b1,  1, 4'b0011, 1'b1, 4'b0100, 1'b0};
    // single pops; the first two also push a pending HOLD while full
    vecs[4]  = '{4'b0011, 1'b1, 1'b0,  1, 4'b0011, 1'b1, 4'b1100, 1'b0};
    vecs[5]  = '{4'b0011, 1'b1, 1'b0,  1, 4'b0011, 1'b1, 4'b0101, 1'b0};
    vecs[6]  = '{4'b0011, 1'b1, 1'b0,  1, 4'b0011, 1'b1, 4'b0111, 1'b0};
    vecs[7]  = '{4'b0011, 1'b1, 1'b0,  1, 4'b0011, 1'b1, 4'b1101, 1'b0};
    vecs[8]  = '{4'b0011, 1'b1, 1'b0,  1, 4'b0011, 1'b1, 4'b1111, 1'b0};
    vecs[9]  = '{4'b0011, 1'b1, 1'b0,  1, 4'b0011, 1'b0, 4'b0000, 1'b0};
    vecs[10] = '{4'b0011, 1'b0, 1'b0,  5, 4'b0011, 1'b0, 4'b0000, 1'b0};
    pct_tbl  = '{0, 10, 50, 90, 100};

    // reset state
    #1;
    check("rst_level", 8'(level), 8'h0);
    check("rst_valid", 8'(ev_valid), 8'h0);
    check("rst_data", 8'(ev_data), 8'h0);
    check("rst_ovf", 8'(ovf), 8'h0);
    cycles(3);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      button = vecs[v].button;
      ev_ready = vecs[v].rdy;
      ovf_clr = vecs[v].clr;
      cycles(vecs[v].ncyc);
      check($sformatf("vec%0d_level", v), 8'(level), 8'(vecs[v].exp_level));
      check($sformatf("vec%0d_valid", v), 8'(ev_valid), 8'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), 8'(ev_data), 8'(vecs[v].exp_data));
      check($sformatf("vec%0d_ovf", v), 8'(ovf), 8'(vecs[v].exp_ovf));
    end
    ovf_clr = 1'b0;

    // b2 toggling every 3 ticks never debounces
    ev_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      button[2] = ~button[2];
      for (int k = 0; k < 3 * TICK_DIV; k++) begin
        cyc();
        check("glitch_level", 8'(level), 8'b0011);
        check("glitch_valid", 8'(ev_valid), 8'h0);
      end
    end

    // queue RELEASE0 and RELEASE1, start a b2 debounce, reset in the middle
    ev_ready = 1'b0;
    button = 4'b0000;
    cycles(60);
    check("pre_rst_level", 8'(level), 8'h0);
    check("pre_rst_valid", 8'(ev_valid), 8'h1);
    check("pre_rst_data", 8'(ev_data), 8'b1000);
    button = 4'b0100;
    cycles(16);
    rst_n = 1'b0;
    #1;
    check("midrst_level", 8'(level), 8'h0);
    check("midrst_valid", 8'(ev_valid), 8'h0);
    check("midrst_data", 8'(ev_data), 8'h0);
    cycles(2);
    rst_n = 1'b1;
    ev_ready = 1'b1;
    for (int k = 0; k < 8 * TICK_DIV; k++) begin
      cyc();
      check("post_rst_quiet", 8'(ev_valid), 8'h0);
    end
    begin
      int waited = 0;
      while (!ev_valid && waited < 40) begin
        ev_ready = 1'b0;
        cyc();
        waited++;
      end
      check("post_rst_event_seen", 8'(ev_valid), 8'h1);
      check("post_rst_event_data", 8'(ev_data), 8'b0110);
      check("post_rst_level", 8'(level), 8'b0100);
    end

    // randomized run against the model
    rst_n = 1'b0;
    button = 4'd0;
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    for (int seg = 0; seg < 32; seg++) begin
      int pct;
      pct = pct_tbl[$urandom_range(0, 4)];
      for (int k = 0; k < 250; k++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 59) == 0) button[b] = ~button[b];
        ev_ready = ($urandom_range(0, 99) < pct);
        ovf_clr = ($urandom_range(0, 99) == 0);
        cyc();
        check("rand_level", 8'(level), 8'(m_level));
        check("rand_valid", 8'(ev_valid), 8'(exp_q.size() != 0));
        check("rand_data", 8'(ev_data), 8'((exp_q.size() != 0) ? exp_q[0] : 4'd0));
        check("rand_ovf", 8'(ovf), 8'(m_ovf));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
